regwrite_trace_fifo: RTL and testbench

Hardware capture buffer for processor register-file write-back events. It sits directly downstream of the processor's register-file write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg) and timestamps every architecturally visible write with a free-running cycle count. It queues each event in a FIFO and drains it over a valid/ready stream to a host link or a checker. It gives on-silicon and in-simulation runs the same "Cycle N: Wrote D into register R" trace the verification flow produces.

---
 rtl/regwrite_trace_fifo_pkg.sv | 15 +
 rtl/regwrite_trace_fifo_sync_fifo.sv | 55 +++++
 rtl/regwrite_trace_fifo.sv | 84 ++++++++
 tb/tb_regwrite_trace_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/regwrite_trace_fifo_pkg.sv
// Shared types and default widths for the register write-back trace buffer.
package trace_pkg;

    localparam int CYCLE_W_DEF = 16;
    localparam int DROP_W_DEF  = 8;
    localparam int RD_W        = 5;
    localparam int DATA_W      = 32;

    typedef struct packed {
        logic [CYCLE_W_DEF-1:0] cycle;
        logic [RD_W-1:0]        rd;
        logic [DATA_W-1:0]      data;
    } trace_entry_t;

endpackage

// File: rtl/regwrite_trace_fifo_sync_fifo.sv
// Register-array FIFO with an explicit occupancy counter; push while full is
// accepted only when a pop happens at the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) wide so they wrap without extra logic.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regwrite_trace_fifo.sv
// Timestamps register-file write-backs with a free-running cycle count and
// queues them for a valid/ready consumer, counting events lost while full.
module regwrite_trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = CYCLE_W_DEF,
    parameter int DROP_W  = DROP_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ctrl_writeEnable,
    input  logic [RD_W-1:0]         ctrl_writeReg,
    input  logic [DATA_W-1:0]       data_writeReg,
    input  logic                    capture_en,
    input  logic                    clear_overflow,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CYCLE_W-1:0]      out_cycle,
    output logic [RD_W-1:0]         out_reg,
    output logic [DATA_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_count
);

    localparam int ENTRY_W = CYCLE_W + RD_W + DATA_W;

    logic [CYCLE_W-1:0] cycle_cnt;
    logic               event_v;
    logic               pop;
    logic               drop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] head;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + CYCLE_W'(1);
    end

    assign event_v = capture_en && ctrl_writeEnable && (ctrl_writeReg != '0);

    // Stream handshake: a transfer happens at a rising edge where out_valid
    // and out_ready are both high; the head stays stable until then.
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign drop      = event_v && full && !pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (event_v),
        .push_data ({cycle_cnt, ctrl_writeReg, data_writeReg}),
        .pop       (pop),
        .pop_data  (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Head fields read as zero whenever the queue is empty.
    assign {out_cycle, out_reg, out_data} = empty ? '0 : head;

    // A drop wins over a simultaneous clear so the loss is never hidden.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;

            if (clear_overflow)
                drop_count <= drop ? DROP_W'(1) : '0;
            else if (drop && !(&drop_count))
                drop_count <= drop_count + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_regwrite_trace_fifo.sv
// Directed bench for regwrite_trace_fifo with a scoreboard of expected entries.
module tb_regwrite_trace_fifo;
    import trace_pkg::*;

    localparam int DEPTH   = 16;
    localparam int ENTRY_W = $bits(trace_entry_t);

    logic        clock;
    logic        reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        capture_en;
    logic        clear_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_cycle;
    logic [4:0]  out_reg;
    logic [31:0] out_data;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    logic [ENTRY_W-1:0] exp_q[$];
    int                 cyc_m;
    logic               ovf_m;
    int                 drops_m;

    regwrite_trace_fifo #(.DEPTH(DEPTH), .CYCLE_W(16), .DROP_W(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .capture_en       (capture_en),
        .clear_overflow   (clear_overflow),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_cycle        (out_cycle),
        .out_reg          (out_reg),
        .out_data         (out_data),
        .count            (count),
        .overflow         (overflow),
        .drop_count       (drop_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cyc_m   = 0;
        ovf_m   = 1'b0;
        drops_m = 0;
    endtask

    // Drive one cycle of inputs, advance one edge, update the scoreboard and
    // compare every output against it.
    task automatic step(input logic we, input logic [4:0] rd, input logic [31:0] d,
                        input logic rdy, input logic cap, input logic clr);
        logic         ev, pp, full_m, drp;
        trace_entry_t e;
        logic [ENTRY_W-1:0] h;
        ctrl_writeEnable = we;
        ctrl_writeReg    = rd;
        data_writeReg    = d;
        out_ready        = rdy;
        capture_en       = cap;
        clear_overflow   = clr;
        ev     = cap && we && (rd != 5'd0);
        pp     = (exp_q.size() != 0) && rdy;
        full_m = (exp_q.size() == DEPTH);
        @(posedge clock);
        #1;
        if (pp) void'(exp_q.pop_front());
        drp = ev && full_m && !pp;
        if (ev && !drp) begin
            e.cycle = cyc_m[15:0];
            e.rd    = rd;
            e.data  = d;
            exp_q.push_back(e);
        end
        if (drp)      ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        if (clr)                      drops_m = drp ? 1 : 0;
        else if (drp && drops_m < 255) drops_m++;
        cyc_m = (cyc_m + 1) & 32'hffff;
        h = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("count", 64'(count), 64'(exp_q.size()));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check("head", 64'({out_cycle, out_reg, out_data}), 64'(h));
        check("overflow", 64'(overflow), 64'(ovf_m));
        check("drop_count", 64'(drop_count), 64'(drops_m));
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 5'd0, 32'd0, rdy, 1'b1, 1'b0);
    endtask

    initial begin
        reset            = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        capture_en       = 1'b1;
        clear_overflow   = 1'b0;
        out_ready        = 1'b0;
        model_reset();
        #12 reset = 1'b0;

        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drops", 64'(drop_count), 64'd0);
        check("rst_head", 64'({out_cycle, out_reg, out_data}), 64'd0);

        // Latency and stamps; r0 and capture_en=0 writes are ignored.
        idle(1'b1);
        idle(1'b1);
        step(1'b1, 5'd0, 32'hdead, 1'b1, 1'b1, 1'b0);
        check("r0_count", 64'(count), 64'd0);
        step(1'b1, 5'd5, 32'h11, 1'b1, 1'b1, 1'b0);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_entry", 64'({out_cycle, out_reg, out_data}), {11'd0, 16'd3, 5'd5, 32'h11});
        step(1'b1, 5'd6, 32'h22, 1'b1, 1'b1, 1'b0);
        check("t2_entry", 64'({out_cycle, out_reg, out_data}), {11'd0, 16'd4, 5'd6, 32'h22});
        step(1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0);
        check("nocap_valid", 64'(out_valid), 64'd0);
        check("nocap_count", 64'(count), 64'd0);
        idle(1'b1);
        step(1'b1, 5'd7, 32'h33, 1'b1, 1'b1, 1'b0);
        check("t3_entry", 64'({out_cycle, out_reg, out_data}), {11'd0, 16'd7, 5'd7, 32'h33});
        idle(1'b1);
        check("t3_drained", 64'(out_valid), 64'd0);

        // Overfill: first write lands at stamp 9.
        for (int i = 0; i < 20; i++)
            step(1'b1, 5'(1 + i % 31), 32'ha000 + 32'(i), 1'b0, 1'b1, 1'b0);
        check("full_count", 64'(count), 64'd16);
        check("full_overflow", 64'(overflow), 64'd1);
        check("full_drops", 64'(drop_count), 64'd4);
        check("full_head", 64'({out_cycle, out_reg, out_data}), {11'd0, 16'd9, 5'd1, 32'ha000});
        idle(1'b0);
        check("held_head", 64'(out_data), 64'ha000);

        // Push and pop at the same edge while full.
        step(1'b1, 5'd20, 32'hb000, 1'b1, 1'b1, 1'b0);
        check("pp_count", 64'(count), 64'd16);
        check("pp_drops", 64'(drop_count), 64'd4);
        check("pp_head", 64'(out_data), 64'ha001);
        for (int i = 0; i < 16; i++) idle(1'b1);
        check("drain_count", 64'(count), 64'd0);

        // Saturation of the drop counter.
        for (int i = 0; i < 16 + 260; i++)
            step(1'b1, 5'd3, 32'(i), 1'b0, 1'b1, 1'b0);
        check("sat_drops", 64'(drop_count), 64'd255);

        // Clear coinciding with a drop, then a plain clear.
        step(1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 1'b1);
        check("clr_drop_ovf", 64'(overflow), 64'd1);
        check("clr_drop_cnt", 64'(drop_count), 64'd1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("clr_ovf", 64'(overflow), 64'd0);
        check("clr_cnt", 64'(drop_count), 64'd0);

        // Asynchronous reset mid-drain.
        for (int i = 0; i < 7; i++) idle(1'b1);
        check("pre_rst_count", 64'(count), 64'd9);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        model_reset();
        #1 reset = 1'b0;
        step(1'b1, 5'd3, 32'hc0de, 1'b0, 1'b1, 1'b0);
        check("post_rst_entry", 64'({out_cycle, out_reg, out_data}), {11'd0, 16'd0, 5'd3, 32'hc0de});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
